// File: rtl/alu_command_sequencer_if.sv
// Command/response bundle between a requester, the command sequencer and the ALU.
// The sequencer takes the slave side; the requester plus ALU environment take the master side.
interface alu_command_sequencer_if;
    // Requester command channel
    logic        CmdValid;
    logic        CmdReady;
    logic [4:0]  CmdFunSel;
    logic        CmdWF;
    logic [2:0]  CmdCond;

    // ALU control and results
    logic [4:0]  FunSel;
    logic        WF;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;

    // Requester response channel
    logic        RspValid;
    logic        RspReady;
    logic [15:0] RspData;
    logic [3:0]  RspFlags;
    logic        RspTaken;

    modport slave (
        input  CmdValid, CmdFunSel, CmdWF, CmdCond, ALUOut, FlagsOut, RspReady,
        output CmdReady, FunSel, WF, RspValid, RspData, RspFlags, RspTaken
    );

    modport master (
        output CmdValid, CmdFunSel, CmdWF, CmdCond, ALUOut, FlagsOut, RspReady,
        input  CmdReady, FunSel, WF, RspValid, RspData, RspFlags, RspTaken
    );
endinterface

// File: rtl/alu_command_sequencer.sv
// Issues one ALU operation per command: drives FunSel/WF for a single cycle,
// waits one cycle for the ALU flag register, then returns result, flags and
// the evaluated condition over a valid/ready response channel.
module alu_command_sequencer (
    input  logic                    Clock,
    input  logic                    Reset,
    alu_command_sequencer_if.slave  bus
);
    localparam int DATA_W = 16;
    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLAGS = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                cmd_ready;
    logic                cmd_accept;

    logic [4:0]          funsel_q;
    logic                wf_q;
    logic [2:0]          cond_q;

    logic [DATA_W-1:0]   rsp_data_q;
    logic [FLAG_W-1:0]   rsp_flags_q;
    logic                rsp_taken_q;
    logic                rsp_valid_q;

    // Flag order is {Z, C, N, O}
    function automatic logic cond_eval(input logic [2:0] cond, input logic [FLAG_W-1:0] flags);
        logic result;
        case (cond)
            3'b000:  result = 1'b1;
            3'b001:  result = flags[3];
            3'b010:  result = ~flags[3];
            3'b011:  result = flags[2];
            3'b100:  result = ~flags[2];
            3'b101:  result = flags[1];
            3'b110:  result = ~flags[1];
            default: result = flags[0];
        endcase
        return result;
    endfunction

    // 8-bit operations only produce a meaningful low byte; clear the rest
    function automatic logic [DATA_W-1:0] width_fix(input logic [DATA_W-1:0] data, input logic wide);
        return wide ? data : {8'h00, data[7:0]};
    endfunction

    // Next-state and command-ready decode
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.CmdValid) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = FLAGS;
            FLAGS: state_nxt = DONE;
            DONE: begin
                // Consuming the response frees the slot for a new command on the same edge
                cmd_ready = bus.RspReady;
                if (bus.RspReady) state_nxt = bus.CmdValid ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_accept = bus.CmdValid & cmd_ready;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latch the accepted command; FunSel keeps the last value between commands
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            funsel_q <= 5'b00000;
            wf_q     <= 1'b0;
            cond_q   <= 3'b000;
        end else if (cmd_accept) begin
            funsel_q <= bus.CmdFunSel;
            wf_q     <= bus.CmdWF;
            cond_q   <= bus.CmdCond;
        end
    end

    // Capture the result at the end of ISSUE, flags and condition at the end of FLAGS
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_taken_q <= 1'b0;
        end else begin
            if (state == ISSUE) rsp_data_q <= width_fix(bus.ALUOut, funsel_q[4]);
            if (state == FLAGS) begin
                rsp_flags_q <= bus.FlagsOut;
                rsp_taken_q <= cond_eval(cond_q, bus.FlagsOut);
            end
        end
    end

    // Response valid rises entering DONE and drops once the response is consumed
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                                rsp_valid_q <= 1'b0;
        else if (state == FLAGS)                  rsp_valid_q <= 1'b1;
        else if (state == DONE && bus.RspReady)   rsp_valid_q <= 1'b0;
    end

    assign bus.CmdReady = cmd_ready;
    assign bus.FunSel   = funsel_q;
    assign bus.WF       = (state == ISSUE) & wf_q;
    assign bus.RspValid = rsp_valid_q;
    assign bus.RspData  = rsp_data_q;
    assign bus.RspFlags = rsp_flags_q;
    assign bus.RspTaken = rsp_taken_q;
endmodule

// File: tb/tb_alu_command_sequencer.sv
// Bench for alu_command_sequencer: small ALU stand-in, queue-based scoreboard
// with an independent monitor, directed cases plus randomized commands.
module tb_alu_command_sequencer;
    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        logic        t;
    } rsp_t;

    logic Clock;
    logic Reset;
    alu_command_sequencer_if intf();

    alu_command_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (intf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wf_cnt = 0;
    int          rise_cyc = 0;
    rsp_t        exp_q[$];
    logic [15:0] last_d;
    logic [3:0]  last_f;
    logic        last_t;

    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_flags = 4'h0;
    logic [3:0]  model_flags = 4'h0;
    logic [19:0] alu_comb;
    logic        rr_mode, rr_manual, rr_rnd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU behaviour: returns {Z,C,N,O, out}. 8-bit ops leave A's high byte on the upper lines.
    function automatic logic [19:0] alu_calc(input logic [4:0] fs, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] fin);
        logic [15:0] m, aa, bb, res;
        logic [16:0] s;
        int          sb;
        logic        c, o;
        m  = fs[4] ? 16'hFFFF : 16'h00FF;
        sb = fs[4] ? 15 : 7;
        aa = a & m;
        bb = b & m;
        c  = fin[2];
        o  = fin[0];
        s  = '0;
        case (fs[3:0])
            4'd1: res = bb;
            4'd4: begin
                s = {1'b0, aa} + {1'b0, bb};
                res = s[15:0] & m;
                c = s[sb+1];
                o = (aa[sb] == bb[sb]) && (res[sb] != aa[sb]);
            end
            4'd5: begin
                s = {1'b0, aa} - {1'b0, bb};
                res = s[15:0] & m;
                c = s[sb+1];
                o = (aa[sb] != bb[sb]) && (res[sb] != aa[sb]);
            end
            4'd8:  res = aa & bb;
            4'd9:  res = aa | bb;
            4'd10: res = aa ^ bb;
            default: res = aa;
        endcase
        return {(res == 16'h0), c, res[sb], o, (fs[4] ? res : {a[15:8], res[7:0]})};
    endfunction

    function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] f);
        logic z, c, n, o;
        {z, c, n, o} = f;
        case (cond)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return n;
            3'd6: return !n;
            default: return o;
        endcase
    endfunction

    // ALU stand-in: combinational result, flags registered when WF is high
    assign alu_comb      = alu_calc(intf.FunSel, alu_a, alu_b, alu_flags);
    assign intf.ALUOut   = alu_comb[15:0];
    assign intf.FlagsOut = alu_flags;
    always @(posedge Clock) if (intf.WF) alu_flags <= alu_comb[19:16];

    always @(posedge Clock) cyc <= cyc + 1;
    always @(negedge Clock) if (intf.WF) wf_cnt <= wf_cnt + 1;

    assign intf.RspReady = rr_mode ? rr_rnd : rr_manual;
    initial begin
        rr_rnd = 1'b1;
        forever begin
            @(posedge Clock);
            #1 rr_rnd = 1'($urandom_range(0, 1));
        end
    end

    // Reference: what the requester should observe for one command, in command order
    task automatic model_step(input logic [4:0] fs, input logic wf, input logic [2:0] cond,
                              input logic [15:0] a, input logic [15:0] b, input bit expect_rsp);
        logic [19:0] r;
        rsp_t        e;
        r = alu_calc(fs, a, b, model_flags);
        if (wf) model_flags = r[19:16];
        e.d = fs[4] ? r[15:0] : {8'h00, r[7:0]};
        e.f = model_flags;
        e.t = cond_true(cond, model_flags);
        if (expect_rsp) exp_q.push_back(e);
    endtask

    // Present a command, wait for acceptance, hold operands through ISSUE
    task automatic send(input logic [4:0] fs, input logic wf, input logic [2:0] cond,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit hold, input bit expect_rsp, output int acc_cyc);
        bit acc;
        int n;
        intf.CmdFunSel = fs;
        intf.CmdWF     = wf;
        intf.CmdCond   = cond;
        alu_a          = a;
        alu_b          = b;
        intf.CmdValid  = 1'b1;
        model_step(fs, wf, cond, a, b, expect_rsp);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge Clock);
            acc = intf.CmdReady;
            @(posedge Clock);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        acc_cyc = cyc;
        @(posedge Clock);
        #1;
        if (!hold) intf.CmdValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge Clock);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    // Monitor: pops the scoreboard on every response handshake, checks stall stability
    initial begin
        logic        hold;
        logic        prev_v;
        logic [20:0] snap;
        rsp_t        e;
        hold = 1'b0;
        prev_v = 1'b0;
        snap = '0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                hold = 1'b0;
                prev_v = 1'b0;
            end else begin
                if (intf.RspValid && !prev_v) rise_cyc = cyc;
                if (hold)
                    chk("rsp_hold", {intf.RspValid, intf.RspData, intf.RspFlags, intf.RspTaken},
                        {1'b1, snap});
                if (intf.RspValid && intf.RspReady) begin
                    chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_data", intf.RspData, e.d);
                        chk("rsp_flags", intf.RspFlags, e.f);
                        chk("rsp_taken", intf.RspTaken, e.t);
                        last_d = intf.RspData;
                        last_f = intf.RspFlags;
                        last_t = intf.RspTaken;
                    end
                end
                hold   = intf.RspValid && !intf.RspReady;
                snap   = {intf.RspData, intf.RspFlags, intf.RspTaken};
                prev_v = intf.RspValid;
            end
        end
    end

    initial begin
        int          acc;
        int          accs[4];
        int          wf0;
        int          n;
        logic [3:0]  ops[7];
        logic [4:0]  fs;
        ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

        intf.CmdValid  = 1'b0;
        intf.CmdFunSel = 5'd0;
        intf.CmdWF     = 1'b0;
        intf.CmdCond   = 3'd0;
        alu_a = 16'h0;
        alu_b = 16'h0;
        rr_mode   = 1'b0;
        rr_manual = 1'b1;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #2;
        chk("rst_cmdready", intf.CmdReady, 1);
        chk("rst_funsel", intf.FunSel, 0);
        chk("rst_wf", intf.WF, 0);
        chk("rst_rspvalid", intf.RspValid, 0);
        chk("rst_rspdata", intf.RspData, 0);
        chk("rst_rspflags", intf.RspFlags, 0);
        chk("rst_rsptaken", intf.RspTaken, 0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;

        // 16-bit ADD FFFF+0001
        wf0 = wf_cnt;
        send(5'b10100, 1'b1, 3'b001, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc);
        drain();
        chk("add_latency", 32'(rise_cyc - acc), 32'd2);
        chk("add_wf_cycles", 32'(wf_cnt - wf0), 32'd1);
        chk("add_data", last_d, 16'h0000);
        chk("add_flags", last_f, 4'b1100);
        chk("add_taken", last_t, 1'b1);

        // 8-bit pass-through
        send(5'b00000, 1'b1, 3'b000, 16'h12AB, 16'h0000, 1'b0, 1'b1, acc);
        drain();
        chk("pass8_data", last_d, 16'h00AB);
        chk("pass8_taken", last_t, 1'b1);

        // Set Z with a SUB, then test !Z without writing flags
        send(5'b10101, 1'b1, 3'b000, 16'h0005, 16'h0005, 1'b0, 1'b1, acc);
        drain();
        wf0 = wf_cnt;
        send(5'b10000, 1'b0, 3'b010, 16'h0007, 16'h0000, 1'b0, 1'b1, acc);
        drain();
        chk("nowf_wf_cycles", 32'(wf_cnt - wf0), 32'd0);
        chk("nowf_z", last_f[3], 1'b1);
        chk("nowf_taken", last_t, 1'b0);
        chk("nowf_data", last_d, 16'h0007);

        // Backpressure with a pending command
        rr_manual = 1'b0;
        send(5'b10100, 1'b1, 3'b011, 16'h8000, 16'h8000, 1'b1, 1'b1, acc);
        intf.CmdFunSel = 5'b10001;
        intf.CmdWF     = 1'b1;
        intf.CmdCond   = 3'b101;
        alu_a = 16'h1111;
        alu_b = 16'h9234;
        model_step(5'b10001, 1'b1, 3'b101, 16'h1111, 16'h9234, 1'b1);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!intf.RspValid && n < 10);
        chk("bp_valid_seen", intf.RspValid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("bp_cmdready", intf.CmdReady, 0);
            chk("bp_rspvalid", intf.RspValid, 1);
        end
        @(posedge Clock);
        #1 rr_manual = 1'b1;
        @(negedge Clock);
        chk("bp_release_cmdready", intf.CmdReady, 1);
        @(posedge Clock);
        #1;
        chk("bp_issue_wf", intf.WF, 1);
        chk("bp_issue_funsel", intf.FunSel, 5'b10001);
        chk("bp_issue_rspvalid", intf.RspValid, 0);
        @(posedge Clock);
        #1 intf.CmdValid = 1'b0;
        drain();

        // Back-to-back with RspReady and CmdValid held high
        for (int i = 0; i < 4; i++) begin
            fs = {1'($urandom_range(0, 1)), ops[$urandom_range(0, 6)]};
            send(fs, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom), (i < 3), 1'b1, accs[i]);
        end
        drain();
        for (int i = 0; i < 3; i++) chk("b2b_spacing", 32'(accs[i+1] - accs[i]), 32'd3);

        // Randomized commands with random response backpressure
        rr_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            fs = {1'($urandom_range(0, 1)), ops[$urandom_range(0, 6)]};
            send(fs, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        intf.CmdValid = 1'b0;
        drain();
        rr_mode = 1'b0;

        // Reset during FLAGS aborts the command
        send(5'b10100, 1'b1, 3'b000, 16'h1234, 16'h0101, 1'b0, 1'b0, acc);
        Reset = 1'b1;
        #1;
        chk("midrst_rspvalid", intf.RspValid, 0);
        chk("midrst_wf", intf.WF, 0);
        chk("midrst_cmdready", intf.CmdReady, 1);
        chk("midrst_funsel", intf.FunSel, 0);
        chk("midrst_rspdata", intf.RspData, 0);
        chk("midrst_rspflags", intf.RspFlags, 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("midrst_no_rsp", intf.RspValid, 0);
        end
        @(posedge Clock);
        #1;
        send(5'b10101, 1'b1, 3'b100, 16'h0003, 16'h0009, 1'b0, 1'b1, acc);
        drain();
        chk("post_rst_data", last_d, 16'hFFFA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_command_sequencer.md
# alu_command_sequencer

Issues single ALU operations on behalf of a requester and returns the result with condition evaluation. Accepts a command (function select, flag-write enable, condition code) over a valid/ready handshake and drives the ALU's `FunSel`/`WF` for exactly one cycle. It then waits one cycle for the ALU's clocked flag register to update. Finally, it returns `ALUOut`, the updated flags and a condition-true bit over a second valid/ready handshake. It sits between the control unit and the ALU as the ALU's command-side counterpart.

## Interface
- No parameters. Data width 16, flag width 4, FunSel width 5 are fixed.
- `Clock` in 1: rising-edge clock, shared with the ALU.
- `Reset` in 1: asynchronous, active-high.
- `CmdValid` in 1: command present.
- `CmdReady` out 1: command accepted on an edge with `CmdValid & CmdReady`.
- `CmdFunSel` in 5: ALU function to issue. Bit 4 = 16-bit mode.
- `CmdWF` in 1: allow the ALU to write flags for this command.
- `CmdCond` in 3: condition to evaluate on post-operation flags.
- `FunSel` out 5: to ALU.
- `WF` out 1: to ALU.
- `ALUOut` in 16: from ALU (combinational).
- `FlagsOut` in 4: from ALU (registered). Bit order: [3]=Z, [2]=C, [1]=N, [0]=O.
- `RspValid` out 1: response present.
- `RspReady` in 1: response consumed on an edge with `RspValid & RspReady`.
- `RspData` out 16: captured result.
- `RspFlags` out 4: captured flags.
- `RspTaken` out 1: condition result.

## Operation
- FSM states: IDLE, ISSUE, FLAGS, DONE. Reset state is IDLE.
- **IDLE:**
  - `CmdReady`=1.
  - On accept, latch `CmdFunSel`/`CmdWF`/`CmdCond`, then go to ISSUE.
- **ISSUE (one cycle):**
  - `FunSel` = latched FunSel.
  - `WF` = latched WF.
  - At the closing edge, capture `ALUOut` into `RspData`, then go to FLAGS.
  - The ALU registers its flags on this same edge.
- **FLAGS (one cycle):**
  - `WF`=0.
  - At the closing edge, capture `FlagsOut` into `RspFlags` and evaluate `CmdCond` on `FlagsOut` into `RspTaken`.
  - Go to DONE.
- **DONE:**
  - `RspValid`=1.
  - `CmdReady` = `RspReady`.
  - On the response handshake edge:
    - With a simultaneous command accept, latch the new command and go to ISSUE.
    - Otherwise go to IDLE.
- **Condition codes:**
  - 000 always 1.
  - 001 Z.
  - 010 !Z.
  - 011 C.
  - 100 !C.
  - 101 N.
  - 110 !N.
  - 111 O.
- **Width rule:**
  - If latched FunSel[4]=0 (8-bit op), `RspData` = {8'h00, ALUOut[7:0]}.
  - Otherwise `RspData` = `ALUOut`.
- **`WF` gating:**
  - `WF` is 1 only in ISSUE with latched `CmdWF`=1, and 0 in every other state.
  - Flags therefore never change outside ISSUE.
  - With `CmdWF`=0, the condition is evaluated on the unchanged prior flags (compare-then-test sequences).
- **`FunSel` holding:** `FunSel` holds the last latched value outside ISSUE. This is harmless, since `WF`=0.
- **Response stability:** `RspData`, `RspFlags` and `RspTaken` hold stable while `RspValid & !RspReady`.
- **Command stall:** a command presented while `CmdReady`=0 is not consumed. The requester must hold it.

## Timing
- **Reset values (asynchronous; all outputs):**
  - State IDLE.
  - `CmdReady`=1.
  - `FunSel`=5'b00000.
  - `WF`=0.
  - `RspValid`=0.
  - `RspData`=16'h0000.
  - `RspFlags`=4'h0.
  - `RspTaken`=0.
- **Latency:** accept at edge E0; `RspValid` rises after E2, i.e. 2 cycles after the accepting cycle.
- **Throughput:** with `RspReady` tied high and `CmdValid` held, one command every 3 cycles (IDLE is skipped via DONE→ISSUE).
- **Reset mid-operation:**
  - Reset in any state aborts the command: no response, `WF` drops to 0 immediately, state returns to IDLE.
  - The ALU flag register is not touched by this block.
- **Outputs:**
  - `CmdReady` and `WF` are decoded from registered state (Moore), except `CmdReady` in DONE, which follows `RspReady` combinationally.
  - `RspValid` is registered.

## Test plan
- **16-bit ADD:** issue FunSel=10100, WF=1, Cond=001 with ALU A=16'hFFFF, B=16'h0001 → `RspValid` 2 cycles after accept; `RspData`=16'h0000; `RspFlags`=4'b1100; `RspTaken`=1; `WF` high for exactly one cycle.
- **8-bit pass-through:** FunSel=00000, WF=1, Cond=000, A=16'h12AB → `RspData`=16'h00AB, `RspTaken`=1.
- **No flag write:** set Z=1 via a 16-bit SUB 16'h0005-16'h0005 with WF=1. Then issue FunSel=10000, WF=0, Cond=010, A=16'h0007 → `WF` stays 0, `RspFlags`[3]=1, `RspTaken`=0, `RspData`=16'h0007.
- **Backpressure:** hold `RspReady`=0 for 5 cycles after `RspValid` → `RspData`/`RspFlags`/`RspTaken` stable, `CmdReady`=0, a pending command is not accepted. Raise `RspReady` with `CmdValid`=1 → the new command enters ISSUE on the same edge.
- **Back-to-back:** `CmdValid` and `RspReady` held high for 4 commands → accepts spaced exactly 3 cycles apart, responses in order.
- **Reset mid-operation:** assert `Reset` during FLAGS → all outputs at reset values immediately, no `RspValid`, next command completes normally.
